// File: rtl/dcache_nway_if.sv
// CPU word port and physical-memory line port of the N-way data cache.
interface dcache_nway_if #(
  parameter int unsigned s_line = 256
);
  logic [31:0]       mem_address;
  logic [3:0]        mem_byte_enable;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_rdata;
  logic [s_line-1:0] pmem_wdata;
  logic              pmem_resp;

  modport master (
    output mem_address, mem_byte_enable, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_address, mem_byte_enable, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way set-associative data cache with tree pseudo-LRU.
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module dcache_nway #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 4
) (
  input logic clk,
  input logic rst,
  dcache_nway_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] writeback_count
`endif
);
  localparam int unsigned s_tag    = 32 - s_offset - s_index;
  localparam int unsigned s_line   = 8 * (2 ** s_offset);
  localparam int unsigned num_sets = 2 ** s_index;
  localparam int unsigned n_bytes  = 2 ** s_offset;
  localparam int unsigned LW       = $clog2(num_ways);
  localparam int unsigned WW       = s_offset - 2;

  typedef logic [s_tag-1:0]    tag_t;
  typedef logic [s_line-1:0]   line_t;
  typedef logic [LW-1:0]       way_t;
  typedef logic [num_ways-1:1] plru_t;
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

  state_t              r_state, w_next;
  logic [31:2]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic                r_write;
  way_t                r_victim;
  logic [num_ways-1:0] r_valid [num_sets];
  logic [num_ways-1:0] r_dirty [num_sets];
  plru_t               r_plru  [num_sets];
  tag_t                r_tag   [num_sets][num_ways];
  line_t               r_data  [num_sets][num_ways];

  logic                r_mem_resp, r_pmem_read, r_pmem_write;
  logic [31:0]         r_mem_rdata, r_pmem_address;
  line_t               r_pmem_wdata;

  logic [s_index-1:0]  w_index;
  tag_t                w_tag;
  logic [WW-1:0]       w_word;
  logic                w_hit, w_has_inv;
  way_t                w_hit_way, w_inv_way, w_victim, w_sel_way;
  line_t               w_hit_line, w_merged;
  logic [31:0]         w_rword;
  logic                w_latch, w_hit_done, w_miss, w_wb_done, w_fill_done;
  logic                w_unused_addr;

  assign w_index       = r_addr[s_offset +: s_index];
  assign w_tag         = r_addr[31 -: s_tag];
  assign w_word        = r_addr[s_offset-1:2];
  assign w_unused_addr = ^bus.mem_address[1:0];

  // Follow the tree bits from the root; the leaf reached is the victim way.
  function automatic way_t plru_victim(input plru_t p);
    logic [LW:0] node;
    node = (LW+1)'(1);
    for (int l = 0; l < int'(LW); l++) node = {node[LW-1:0], p[node[LW-1:0]]};
    return node[LW-1:0];
  endfunction

  function automatic plru_t plru_touch(input plru_t p, input way_t way);
    plru_t       q;
    logic [LW:0] node;
    q    = p;
    node = (LW+1)'(1);
    for (int l = 0; l < int'(LW); l++) begin
      q[node[LW-1:0]] = ~way[int'(LW)-1-l];
      node            = {node[LW-1:0], way[int'(LW)-1-l]};
    end
    return q;
  endfunction

  // Tag match plus lowest invalid way.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = int'(num_ways) - 1; w >= 0; w--) begin
      if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = way_t'(w);
      end
      if (!r_valid[w_index][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = way_t'(w);
      end
    end
    w_victim  = w_has_inv ? w_inv_way : plru_victim(r_plru[w_index]);
    w_sel_way = (r_state == CHECK) ? w_victim : r_victim;
  end

  assign w_hit_line = r_data[w_index][w_hit_way];
  assign w_rword    = w_hit_line[{w_word, 5'b0} +: 32];

  always_comb begin
    w_merged = w_hit_line;
    for (int b = 0; b < int'(n_bytes); b++) begin
      if ((w_word == WW'(b / 4)) && r_be[b % 4]) w_merged[8*b +: 8] = r_wdata[8*(b % 4) +: 8];
    end
  end

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_hit_done  = 1'b0;
    w_miss      = 1'b0;
    w_wb_done   = 1'b0;
    w_fill_done = 1'b0;
    case (r_state)
      IDLE: begin
        // The previous request is still held during its mem_resp cycle.
        if ((bus.mem_read || bus.mem_write) && !r_mem_resp) begin
          w_latch = 1'b1;
          w_next  = CHECK;
        end
      end
      CHECK: begin
        if (w_hit) begin
          w_hit_done = 1'b1;
          w_next     = IDLE;
        end else begin
          w_miss = 1'b1;
          w_next = (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (bus.pmem_resp) begin
          w_wb_done = 1'b1;
          w_next    = FILL;
        end
      end
      FILL: begin
        if (bus.pmem_resp) begin
          w_fill_done = 1'b1;
          w_next      = CHECK;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, request latch, metadata and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_be           <= '0;
      r_write        <= 1'b0;
      r_victim       <= '0;
      r_mem_resp     <= 1'b0;
      r_mem_rdata    <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      for (int s = 0; s < int'(num_sets); s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr  <= bus.mem_address[31:2];
        r_wdata <= bus.mem_wdata;
        r_be    <= bus.mem_byte_enable;
        r_write <= bus.mem_write;
      end
      if (w_miss) r_victim <= w_victim;
      if (w_hit_done) begin
        r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
        if (r_write) r_dirty[w_index][w_hit_way] <= 1'b1;
      end
      if (w_wb_done) r_dirty[w_index][r_victim] <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_index][r_victim] <= 1'b1;
        r_dirty[w_index][r_victim] <= 1'b0;
      end
      r_mem_resp   <= w_hit_done;
      r_mem_rdata  <= w_hit_done ? w_rword : '0;
      r_pmem_read  <= (w_next == FILL);
      r_pmem_write <= (w_next == WRITEBACK);
      case (w_next)
        WRITEBACK: r_pmem_address <= {r_tag[w_index][w_sel_way], w_index, {s_offset{1'b0}}};
        FILL:      r_pmem_address <= {w_tag, w_index, {s_offset{1'b0}}};
        default:   r_pmem_address <= '0;
      endcase
      r_pmem_wdata <= (w_next == WRITEBACK) ? r_data[w_index][w_sel_way] : '0;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_index][r_victim]  <= w_tag;
      r_data[w_index][r_victim] <= bus.pmem_rdata;
    end else if (w_hit_done && r_write) begin
      r_data[w_index][w_hit_way] <= w_merged;
    end
  end

  assign bus.mem_resp     = r_mem_resp;
  assign bus.mem_rdata    = r_mem_rdata;
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;

`ifdef DCACHE_PERF_CNT_EN
  logic        r_refill;
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  // The CHECK that follows a fill is not a first-pass hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refill   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_fill_done) r_refill <= 1'b1;
      else if (r_state == CHECK) r_refill <= 1'b0;
      if (w_hit_done && !r_refill && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_wb_done && (r_wb_cnt != '1)) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_count       = r_hit_cnt;
  assign miss_count      = r_miss_cnt;
  assign writeback_count = r_wb_cnt;
`endif
endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate, N-way set-associative data cache. Next generation of the team's fixed 4-way data cache.
- Sits between the CPU data port (32-bit word interface, byte enables) and physical memory / arbiter (one cache line per transfer).
- Generalises way count and set count, and replaces the fixed 3-bit LRU with tree pseudo-LRU.
- Adds explicit miss FSM, dirty-victim writeback, and optional performance counters.

Parameters:
- s_offset, 5, line offset bits; line = 2**s_offset bytes; pmem data width s_line = 8*2**s_offset.
- s_index, 3, set index bits; num_sets = 2**s_index.
- num_ways, 4, associativity; power of two, range 2..16.
- s_tag, 32-s_offset-s_index, tag bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_address  in  32  CPU byte address; low 2 bits ignored.
- mem_byte_enable  in  4  byte enables for writes.
- mem_read  in  1  CPU read request.
- mem_write  in  1  CPU write request; never asserted together with mem_read.
- mem_wdata  in  32  CPU write data.
- mem_rdata  out  32  read data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned address; low s_offset bits are 0.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_rdata  in  s_line  fill data.
- pmem_wdata  out  s_line  writeback data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- Reset: clears all valid, dirty and PLRU bits, FSM goes to IDLE, and all outputs go to 0. Tag and data arrays are not cleared. Reset mid-miss abandons the transaction and drops pmem_read/pmem_write the next cycle.
- Handshake: CPU holds address, enables and data stable from request until the mem_resp cycle inclusive. CPU may issue a new request in the cycle after mem_resp.
- FSM states: IDLE, CHECK, WRITEBACK, FILL.
  - IDLE: on mem_read|mem_write, latch the request and go to CHECK.
  - CHECK, hit: assert mem_resp this cycle. Read returns the word from the hit way. Write merges bytes per mem_byte_enable and sets dirty. Update PLRU to the hit way. Go to IDLE. Hit latency is 2 cycles from request to mem_resp.
  - CHECK, miss: select victim = the lowest-numbered invalid way if any, else the PLRU way. Victim valid and dirty -> WRITEBACK; otherwise -> FILL.
  - WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line. Hold until pmem_resp, then clear dirty and go to FILL.
  - FILL: pmem_read=1, pmem_address={req tag, index, 0}. On pmem_resp, write the line into the victim way, set valid and tag, clear dirty, and go to CHECK; the request then hits.
- pmem_read and pmem_write are never high together, and each is held continuously until pmem_resp.
- PLRU: num_ways-1 bits per set, binary tree. Every access flips the path bits to point away from the accessed way.
- Data merge: byte-lane enable for a 32-bit word write = mem_byte_enable shifted by 4*address[s_offset-1:2]. The read mux uses the same word select.
- A pmem_resp outside WRITEBACK or FILL is ignored.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count (32), miss_count (32) and writeback_count (32).
  - Each counts completed events: hit_count on a first-pass CHECK hit, miss_count on a CHECK miss, writeback_count on a WRITEBACK pmem_resp.
  - A post-fill CHECK does not count as a hit.
  - Counters saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Cold read 0x0000_0040 after reset: pmem_read with pmem_address=0x40, memory returns a line whose word 0 = 0xDEADBEEF. Then mem_resp=1 and mem_rdata=0xDEADBEEF; a repeat read hits with mem_resp 2 cycles after request and no pmem activity.
- Write 0x0000_0044, byte_enable=4'b0011, wdata=0x1234_5678 to a resident line holding 0xAAAA_AAAA: a subsequent read returns 0xAAAA_5678 and the line is dirty.
- Fill all num_ways=4 ways of set 2 (addresses 0x40, 0x140, 0x240, 0x340), touch 0x40 again, then read 0x440: victim is the PLRU way, and 0x40 is not evicted.
- Dirty victim: write 0x140, then force its eviction. pmem_write with pmem_address=0x140 carrying the written data strictly precedes pmem_read of the new line.
- Assert rst during FILL: next cycle pmem_read=0 and mem_resp=0; a subsequent read of the same address misses again.
- With DCACHE_PERF_CNT_EN: scenario-1 sequence gives hit_count=1, miss_count=1, writeback_count=0.
